// File: rtl/fifo_stream_reader.sv
// Pulls words from a synchronous FIFO into a 2-entry skid buffer and emits them as a
// valid/ready stream, grouped into PKT_LEN-word packets with a last marker.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int PKT_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic [31:0]           words_sent,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [15:0] LAST_BEAT = 16'(PKT_LEN - 1);

  state_t                state;
  logic [1:0]            occ;
  logic                  pend;
  logic [15:0]           beat_cnt;
  logic [DATA_WIDTH-1:0] entry0;
  logic [DATA_WIDTH-1:0] entry1;
  logic                  pop;
  logic [2:0]            level;

  // A read is only issued when the buffer is guaranteed to have room on the capture edge.
  assign pop        = m_valid && m_ready;
  assign level      = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
  assign fifo_rd_en = !rst && enable && !fifo_empty && (level < 3'd2);

  assign m_valid = (occ != 2'd0);
  assign m_data  = entry0;
  assign m_last  = m_valid && (beat_cnt == LAST_BEAT);
  assign busy    = (occ != 2'd0) || pend;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      occ        <= 2'd0;
      pend       <= 1'b0;
      beat_cnt   <= 16'd0;
      words_sent <= 32'd0;
      entry0     <= '0;
      entry1     <= '0;
    end else begin
      pend <= fifo_rd_en;

      // entry0 is always the oldest word; a capture lands behind whatever survives the pop.
      case ({pend, pop})
        2'b10: begin
          if (occ == 2'd0) entry0 <= fifo_data;
          else             entry1 <= fifo_data;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            entry0 <= entry1;
            entry1 <= fifo_data;
          end else begin
            entry0 <= fifo_data;
          end
        end
        default: ;
      endcase

      if (pop) begin
        words_sent <= words_sent + 32'd1;
        beat_cnt   <= m_last ? 16'd0 : beat_cnt + 16'd1;
      end

      case (state)
        IDLE:    if (enable) state <= RUN;
        RUN:     if (!enable) state <= busy ? DRAIN : IDLE;
        DRAIN: begin
          if (enable)     state <= RUN;
          else if (!busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  idle_means_empty: assert property (@(posedge clk) disable iff (rst) (state == IDLE) |-> !busy);

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: a cycle table for the buffer corner cases,
// then streaming, backpressure, empty gaps, drain, mid-packet reset and PKT_LEN=1.
module tb_fifo_stream_reader;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_empty, fifo_rd_en, m_valid, m_last, busy;
  logic [DW-1:0] fifo_data, m_data;
  logic [31:0]   words_sent;

  logic          use_tbl = 1'b0;
  logic          tbl_empty = 1'b1;
  logic [DW-1:0] tbl_data = '0;

  logic [DW-1:0] mem [0:1023];
  logic [9:0]    rd_ptr;
  logic [9:0]    wr_ptr = '0;
  logic [DW-1:0] model_data = '0;
  logic          gap = 1'b0;
  logic          fifo_flush = 1'b1;

  logic          fifo_empty1, fifo_rd_en1, m_valid1, m_last1, busy1;
  logic [DW-1:0] fifo_data1 = '0;
  logic [DW-1:0] m_data1;
  logic [31:0]   words_sent1;
  logic [7:0]    cnt1 = '0;
  logic [7:0]    lim1 = '0;

  int checks = 0;
  int errors = 0;

  // Upstream FIFO model: data is registered on the edge that accepts the read.
  assign fifo_empty = use_tbl ? tbl_empty : ((rd_ptr == wr_ptr) || gap);
  assign fifo_data  = use_tbl ? tbl_data : model_data;

  always @(posedge clk) begin
    if (fifo_flush) rd_ptr <= wr_ptr;
    else if (!use_tbl && fifo_rd_en && !fifo_empty) begin
      model_data <= mem[rd_ptr];
      rd_ptr     <= rd_ptr + 10'd1;
    end
  end

  assign fifo_empty1 = (cnt1 == lim1);
  always @(posedge clk) begin
    if (fifo_rd_en1 && !fifo_empty1) begin
      fifo_data1 <= 32'hA0 + {24'd0, cnt1};
      cnt1       <= cnt1 + 8'd1;
    end
  end

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(16)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .words_sent(words_sent), .busy(busy)
  );

  fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty1), .fifo_rd_en(fifo_rd_en1),
    .fifo_data(fifo_data1), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
    .m_last(m_last1), .words_sent(words_sent1), .busy(busy1)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, en, empty;
    logic [31:0] data;
    logic        rdy;
    logic        exp_rd, exp_valid;
    logic [31:0] exp_data;
    logic        exp_last, exp_busy;
    logic [31:0] exp_words;
  } vec_t;

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    rst       = v.rst;
    enable    = v.en;
    tbl_empty = v.empty;
    tbl_data  = v.data;
    m_ready   = v.rdy;
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst = 1'b1; fifo_flush = 1'b1; enable = 1'b0; m_ready = 1'b0; gap = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; fifo_flush = 1'b0;
  endtask

  task automatic preload(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = base + i;
      wr_ptr      = wr_ptr + 10'd1;
    end
  endtask

  // Always-on protocol checks: no read while empty or in reset, no buffer overflow,
  // and a stalled word must hold still until it is taken.
  int            outstanding = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    int pop_i, acc_i;
    #2;
    pop_i = (m_valid === 1'b1 && m_ready === 1'b1) ? 1 : 0;
    acc_i = (fifo_rd_en === 1'b1 && fifo_empty === 1'b0) ? 1 : 0;
    if (fifo_rd_en === 1'b1) begin
      checkOutput("rd_en_empty_or_rst", {31'd0, fifo_empty | rst}, 32'd0);
      checkOutput("no_overflow", {31'd0, (outstanding + 1 - pop_i) <= 2}, 32'd1);
    end
    if (prev_stall && !rst) begin
      checkOutput("stall_valid", {31'd0, m_valid}, 32'd1);
      checkOutput("stall_data", m_data, prev_data);
      checkOutput("stall_last", {31'd0, m_last}, {31'd0, prev_last});
    end
    if (rst) begin
      outstanding = 0;
      prev_stall  = 1'b0;
    end else begin
      outstanding = outstanding + acc_i - pop_i;
      prev_stall  = (m_valid === 1'b1) && (m_ready === 1'b0);
      prev_data   = m_data;
      prev_last   = m_last;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[$];
    int   idx, got;

    // rst en empty data rdy | rd_en valid data last busy words
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 1'b1, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h22, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h99, 1'b0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b1, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h11, 1'b0, 1'b1, 32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 32'h22, 1'b0, 1'b1, 32'd1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h77, 1'b0, 1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 32'd2});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 32'h33, 1'b0, 1'b1, 32'd2});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'd3});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 1'b0, 32'd3});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 32'h44, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b1, 32'd3});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h55, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 32'd0});

    $display("[TB] reset state");
    applyReset();
    #1;
    checkOutput("rst_valid", {31'd0, m_valid}, 32'd0);
    checkOutput("rst_last", {31'd0, m_last}, 32'd0);
    checkOutput("rst_data", m_data, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_words", words_sent, 32'd0);
    checkOutput("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);

    $display("[TB] cycle table");
    use_tbl = 1'b1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("tbl%0d_rd_en", i), {31'd0, fifo_rd_en}, {31'd0, vecs[i].exp_rd});
      checkOutput($sformatf("tbl%0d_valid", i), {31'd0, m_valid}, {31'd0, vecs[i].exp_valid});
      checkOutput($sformatf("tbl%0d_last", i), {31'd0, m_last}, {31'd0, vecs[i].exp_last});
      checkOutput($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
      checkOutput($sformatf("tbl%0d_words", i), words_sent, vecs[i].exp_words);
      if (vecs[i].exp_valid) checkOutput($sformatf("tbl%0d_data", i), m_data, vecs[i].exp_data);
    end
    @(negedge clk);
    use_tbl = 1'b0;

    $display("[TB] streaming 40 words");
    applyReset();
    preload(40, 0);
    enable = 1'b1; m_ready = 1'b1;
    #1;
    checkOutput("s1_rd_first", {31'd0, fifo_rd_en}, 32'd1);
    checkOutput("s1_valid_n", {31'd0, m_valid}, 32'd0);
    @(negedge clk); #1;
    checkOutput("s1_valid_n1", {31'd0, m_valid}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      checkOutput($sformatf("s1_valid%0d", i), {31'd0, m_valid}, 32'd1);
      checkOutput($sformatf("s1_data%0d", i), m_data, i);
      checkOutput($sformatf("s1_last%0d", i), {31'd0, m_last}, {31'd0, (i % 16) == 15});
    end
    @(negedge clk);
    enable = 1'b0;
    #1;
    checkOutput("s1_words", words_sent, 32'd40);
    checkOutput("s1_valid_end", {31'd0, m_valid}, 32'd0);

    $display("[TB] backpressure 100 words");
    applyReset();
    preload(100, 1000);
    enable = 1'b1;
    idx = 0;
    for (int c = 0; c < 2000 && idx < 100; c++) begin
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (m_valid && m_ready) begin
        checkOutput($sformatf("s2_data%0d", idx), m_data, 1000 + idx);
        idx++;
      end
    end
    checkOutput("s2_count", idx, 32'd100);
    @(negedge clk);
    enable = 1'b0; m_ready = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    checkOutput("s2_no_extra", {31'd0, m_valid}, 32'd0);
    checkOutput("s2_words", words_sent, 32'd100);

    $display("[TB] empty gaps");
    applyReset();
    preload(12, 2000);
    m_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 300 && idx < 12; c++) begin
      @(negedge clk);
      enable = 1'b1;
      gap = ((c / 3) % 2) == 1;
      #1;
      if (gap && (c % 3) == 2) checkOutput($sformatf("s3_busy_gap%0d", c), {31'd0, busy}, 32'd0);
      if (m_valid) begin
        checkOutput($sformatf("s3_data%0d", idx), m_data, 2000 + idx);
        idx++;
      end
    end
    checkOutput("s3_count", idx, 32'd12);
    gap = 1'b0;

    $display("[TB] drain");
    applyReset();
    preload(10, 3000);
    enable = 1'b1; m_ready = 1'b0;
    #1;
    checkOutput("s4_rd_n", {31'd0, fifo_rd_en}, 32'd1);
    @(negedge clk); #1;
    checkOutput("s4_rd_n1", {31'd0, fifo_rd_en}, 32'd1);
    @(negedge clk);
    enable = 1'b0; m_ready = 1'b1;
    #1;
    checkOutput("s4_busy_start", {31'd0, busy}, 32'd1);
    got = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) begin
        @(negedge clk); #1;
      end
      checkOutput($sformatf("s4_no_read%0d", k), {31'd0, fifo_rd_en}, 32'd0);
      if (m_valid) begin
        checkOutput($sformatf("s4_data%0d", got), m_data, 3000 + got);
        got++;
      end
    end
    checkOutput("s4_count", got, 32'd2);
    checkOutput("s4_busy_end", {31'd0, busy}, 32'd0);

    $display("[TB] reset mid-packet");
    applyReset();
    preload(30, 4000);
    enable = 1'b1; m_ready = 1'b1;
    idx = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk); #1;
      if (m_valid) begin
        checkOutput($sformatf("s5_pre_data%0d", idx), m_data, 4000 + idx);
        checkOutput($sformatf("s5_pre_last%0d", idx), {31'd0, m_last}, 32'd0);
        idx++;
      end
      if (idx == 6) break;
    end
    checkOutput("s5_pre_count", idx, 32'd6);
    @(negedge clk);
    rst = 1'b1; fifo_flush = 1'b1;
    #1;
    checkOutput("s5_busy_at_rst", {31'd0, busy}, 32'd1);
    @(negedge clk);
    rst = 1'b0; fifo_flush = 1'b0; enable = 1'b0;
    #1;
    checkOutput("s5_valid_after", {31'd0, m_valid}, 32'd0);
    checkOutput("s5_busy_after", {31'd0, busy}, 32'd0);
    checkOutput("s5_words_after", words_sent, 32'd0);
    preload(20, 5000);
    @(negedge clk);
    enable = 1'b1;
    idx = 0;
    for (int c = 0; c < 60 && idx < 16; c++) begin
      @(negedge clk); #1;
      if (m_valid) begin
        checkOutput($sformatf("s5_data%0d", idx), m_data, 5000 + idx);
        checkOutput($sformatf("s5_last%0d", idx), {31'd0, m_last}, {31'd0, idx == 15});
        idx++;
      end
    end
    checkOutput("s5_count", idx, 32'd16);
    @(negedge clk);
    enable = 1'b0;
    #1;
    checkOutput("s5_words", words_sent, 32'd16);

    $display("[TB] PKT_LEN=1");
    applyReset();
    lim1 = 8'd4;
    enable = 1'b1; m_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (m_valid1) begin
        checkOutput($sformatf("s6_data%0d", got), m_data1, 32'hA0 + got);
        checkOutput($sformatf("s6_last%0d", got), {31'd0, m_last1}, 32'd1);
        got++;
      end
    end
    checkOutput("s6_count", got, 32'd4);
    checkOutput("s6_words", words_sent1, 32'd4);
    enable = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of FIFO and stream data.
REQ-002 Parameter PKT_LEN, default 16, words per packet, range 1..65535.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  permits new FIFO reads when high.
REQ-006 fifo_empty  input  1  empty flag from the upstream synchronous FIFO.
REQ-007 fifo_rd_en  output  1  read request to the upstream FIFO.
REQ-008 fifo_data  input  DATA_WIDTH  FIFO read data, registered by the FIFO on the edge that accepts the read.
REQ-009 m_valid  output  1  stream word valid.
REQ-010 m_ready  input  1  stream consumer ready.
REQ-011 m_data  output  DATA_WIDTH  stream word.
REQ-012 m_last  output  1  marks the final word of each PKT_LEN-word packet.
REQ-013 words_sent  output  32  count of completed stream handshakes, wraps 2^32-1 -> 0.
REQ-014 busy  output  1  high when any word is in flight or buffered.

Function
REQ-015 Read accepted: fifo_rd_en=1 and fifo_empty=0 at edge E; fifo_data valid after E; reader captures it into the output buffer at edge E+1.
REQ-016 Output buffer holds 2 entries (skid); occ in 0..2; pend in 0..1, where pend is 1 if a read was accepted at the previous edge.
REQ-017 pop = m_valid && m_ready; fifo_rd_en = enable && !fifo_empty && (occ + pend - pop) < 2, combinational.
REQ-018 fifo_rd_en never asserted while fifo_empty=1 or rst=1.
REQ-019 Sustained throughput is one word per clock when FIFO is non-empty and m_ready stays high.
REQ-020 First-word latency: rd_en cycle N -> m_valid high in cycle N+2.
REQ-021 m_valid = (occ != 0); m_data/m_last are the oldest entry; words leave in FIFO order.
REQ-022 With m_valid=1 and m_ready=0, m_data and m_last remain stable until the handshake.
REQ-023 Simultaneous capture and pop in one edge: occ unchanged; new word enters behind the remaining entry.
REQ-024 beat_cnt (16 bit) increments on pop; m_last = (beat_cnt == PKT_LEN-1); on pop with m_last, beat_cnt -> 0. PKT_LEN=1 gives m_last on every word.
REQ-025 words_sent increments by 1 on each pop.
REQ-026 FSM states: IDLE (enable=0, occ=0, pend=0), RUN (enable=1), DRAIN (enable=0, occ+pend>0).
REQ-027 Transitions: IDLE->RUN on enable=1; RUN->DRAIN on enable=0 with occ+pend>0; RUN->IDLE on enable=0 with occ+pend=0; DRAIN->IDLE when occ+pend=0; DRAIN->RUN on enable=1.
REQ-028 DRAIN: no new reads; buffered and in-flight words are still delivered.
REQ-029 busy = (occ + pend != 0).
REQ-030 Entries never overflow: capture with occ=2 and no pop is unreachable under REQ-017.

Reset
REQ-031 At the rst edge: state=IDLE, occ=0, pend=0, beat_cnt=0, words_sent=0, m_valid=0, m_last=0, m_data=0, busy=0.
REQ-032 Reset mid-operation drops buffered words and discards the in-flight read; no capture occurs on the edge after reset.
REQ-033 fifo_rd_en=0 in every cycle where rst=1.

Verification
REQ-034 Streaming: FIFO preloaded with 0..39, enable=1, m_ready=1 -> 40 words 0..39 in consecutive cycles after a 2-cycle latency; m_last on words 15 and 31; words_sent=40.
REQ-035 Backpressure: m_ready random 50% over 100 words -> order intact, no loss or duplicate, data stable while stalled, fifo_rd_en low whenever occ+pend-pop=2.
REQ-036 Empty gaps: fifo_empty toggles every 3 cycles -> fifo_rd_en never high with fifo_empty=1; busy=0 during gaps.
REQ-037 Drain: enable dropped with occ=1, pend=1 -> exactly 2 more words delivered, no new reads, state DRAIN->IDLE, busy falls.
REQ-038 Reset mid-packet: rst pulsed after word 5 with a read in flight -> the in-flight word does not appear; after reset, the next packet's m_last is on its 16th word; words_sent restarts at 0.
REQ-039 PKT_LEN=1: 4 words -> m_last=1 on all 4 words.
